pipe_buf_elastic_reg: RTL and testbench
=======================================

Name: pipe_buf_elastic_reg

Overview:
Parametrised elastic pipeline buffer register for the IF/ID, ID/EX, EX/MEM and MEM/WB stage boundaries.
- Carries any packed stage struct as a flat DATA_W payload.
- Uses a valid/ready handshake with a two-entry skid buffer, so upstream never sees a combinational path from out_ready.
- Adds flush with bubble (NOP) insertion, occupancy reporting and a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 41, payload width in bits (one flattened stage struct).
- NOP_VAL, 'h13 zero-extended to DATA_W, payload driven on out_data when the buffer is empty or flushed; places addi x0,x0,0 in the low 32 bits.
- CNT_W, 16, width of stall_cycles counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- flush  input  1  synchronous kill of all buffered entries
- in_valid  input  1  upstream payload valid
- in_ready  output  1  buffer can accept this cycle
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  out_data holds a live entry
- out_ready  input  1  downstream accepts this cycle
- out_data  output  DATA_W  oldest live payload, or NOP_VAL when empty
- occupancy  output  2  live entries, 0..2
- stall_cycles  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- clr_cnt  input  1  synchronous clear of stall_cycles

Behaviour:
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Registers: main (data plus valid) and skid (data plus valid).
  - out_data = main data.
  - out_valid = main valid.
  - in_ready = !skid valid. in_ready is a function of registered state only.
- State, encoded by occupancy:
  - EMPTY (0): in_fire -> ONE, main <= in_data.
  - ONE (1), no in_fire, no out_fire -> hold.
  - ONE (1), in_fire & !out_fire -> FULL, skid <= in_data.
  - ONE (1), in_fire & out_fire -> ONE, main <= in_data (full throughput, 1 entry/cycle).
  - ONE (1), !in_fire & out_fire -> EMPTY, main data <= NOP_VAL.
  - FULL (2): in_ready=0, so no in_fire is possible. out_fire -> ONE, main <= skid, skid data <= NOP_VAL. Otherwise hold.
- Latency: in_fire at edge N makes the data visible on out_data after edge N. Minimum latency is 1 cycle.
- Ordering: strict FIFO; no entry is dropped or duplicated except by flush.
- Stability: while out_valid=1 and out_ready=0, out_data is held stable.
- flush has highest priority over all handshakes.
  - Next state is EMPTY; main and skid data <= NOP_VAL; both valids <= 0.
  - Any in_fire and out_fire in the same cycle are ignored: the entry is discarded, not stored. Upstream must not count it as accepted; upstream asserts flush only when it also redirects fetch.
- stall_cycles:
  - Increments by 1 each cycle with out_valid & !out_ready, including the flush cycle, evaluated before flush takes effect.
  - Saturates at 2^CNT_W-1; never wraps.
  - clr_cnt has priority over increment and loads 0.
  - Not cleared by flush.
- Reset values (asynchronous, reset=0):
  - occupancy=0, out_valid=0, out_data=NOP_VAL.
  - skid data=NOP_VAL, skid valid=0, in_ready=1.
  - stall_cycles=0.
- Reset mid-operation drops all entries immediately, without waiting for a clock edge. Operation resumes on the first rising edge after reset is deasserted.
- Arithmetic: only the counter uses arithmetic, as an unsigned CNT_W-bit add with a saturation compare. Payload is never modified.
- No X propagation: in_data is sampled only on in_fire.

Test Plan:
1. Streaming, DATA_W=41: out_ready=1, in_valid=1 with in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each; in_ready stays 1; occupancy stays 1; stall_cycles=0.
2. Backpressure: out_ready=0, push A=0x0AA then B=0x0BB -> occupancy=2, in_ready=0, out_data=0x0AA held, stall_cycles increments. Then out_ready=1 -> 0x0AA then 0x0BB; occupancy goes 2->1->0; out_data=0x13 when empty.
3. Flush while FULL with in_valid=1, in_data=0x0CC on the same cycle -> next cycle occupancy=0, out_valid=0, out_data=0x13, in_ready=1; 0x0CC never appears on out_data.
4. Simultaneous push and pop in ONE: main=0x111, in_data=0x222, out_ready=1 -> next cycle out_data=0x222, occupancy=1.
5. Counter, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cycles=15 and stays 15. Then pulse clr_cnt -> 0, and counting resumes from 1.
6. Async reset asserted mid-cycle while FULL -> outputs go to reset values without waiting for a clock edge. After deassertion, first push 0x055 appears on out_data after one edge.

Source files
------------

// File: rtl/pipe_buf_elastic_reg.sv
// Elastic pipeline buffer register for a stage boundary.
// Two registers (main and skid) carry a flattened stage payload. in_ready
// depends only on registered state, so out_ready never reaches upstream
// combinationally. Adds flush with NOP insertion, occupancy reporting and a
// saturating stall-cycle counter.
module pipe_buf_elastic_reg #(
  parameter int unsigned          DATA_W  = 41,
  parameter logic [DATA_W-1:0]    NOP_VAL = DATA_W'(32'h0000_0013),
  parameter int unsigned          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles,
  input  logic              clr_cnt
);

  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic in_fire_s;
  logic out_fire_s;

  // Handshake events; both sides see only registered valid/ready state.
  always_comb begin
    in_fire_s  = in_valid & ~skid_valid_q;
    out_fire_s = main_valid_q & out_ready;
  end

  // Next-state for the two payload registers; flush overrides every handshake.
  always_comb begin
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_data_d  = NOP_VAL;
      main_valid_d = 1'b0;
      skid_data_d  = NOP_VAL;
      skid_valid_d = 1'b0;
    end else begin
      case ({skid_valid_q, main_valid_q})
        2'b00: begin
          // EMPTY: a new entry goes straight into main.
          if (in_fire_s) begin
            main_data_d  = in_data;
            main_valid_d = 1'b1;
          end else begin
            main_data_d  = main_data_q;
          end
        end
        2'b01: begin
          // ONE: push parks in skid unless main is draining the same cycle.
          case ({in_fire_s, out_fire_s})
            2'b10: begin
              skid_data_d  = in_data;
              skid_valid_d = 1'b1;
            end
            2'b11: begin
              main_data_d  = in_data;
            end
            2'b01: begin
              main_data_d  = NOP_VAL;
              main_valid_d = 1'b0;
            end
            default: begin
              main_data_d  = main_data_q;
            end
          endcase
        end
        2'b11: begin
          // FULL: no push possible; a pop promotes skid into main.
          if (out_fire_s) begin
            main_data_d  = skid_data_q;
            skid_data_d  = NOP_VAL;
            skid_valid_d = 1'b0;
          end else begin
            main_data_d  = main_data_q;
          end
        end
        default: begin
          // Skid live with main empty cannot arise; recover by promoting skid.
          main_data_d  = skid_data_q;
          main_valid_d = 1'b1;
          skid_data_d  = NOP_VAL;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Stall counter: clear wins, otherwise saturating count of blocked cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data_q  <= NOP_VAL;
      main_valid_q <= 1'b0;
      skid_data_q  <= NOP_VAL;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      main_data_q  <= main_data_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Outputs are straight views of registered state.
  always_comb begin
    out_data     = main_data_q;
    out_valid    = main_valid_q;
    in_ready     = ~skid_valid_q;
    occupancy    = {skid_valid_q, main_valid_q & ~skid_valid_q};
    stall_cycles = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipe_buf_elastic_reg.sv
// Directed table-driven bench for pipe_buf_elastic_reg (DATA_W=41, CNT_W=4).
module tb_pipe_buf_elastic_reg;

  localparam int unsigned DW = 41;
  localparam int unsigned CW = 4;
  localparam logic [DW-1:0] NOP = 41'h13;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cycles;
  logic          clr_cnt;

  int checks;
  int errors;

  pipe_buf_elastic_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles),
    .clr_cnt      (clr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          clr;
    logic          ev;
    logic [DW-1:0] ed;
    logic [1:0]    eocc;
    logic          einr;
    logic [CW-1:0] est;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [DW-1:0] d,
                              input logic ordy, input logic clr, input logic ev,
                              input logic [DW-1:0] ed, input logic [1:0] eocc,
                              input logic einr, input logic [CW-1:0] est);
    vec_t v;
    v.flush = fl; v.in_valid = iv; v.in_data = d; v.out_ready = ordy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.eocc = eocc; v.einr = einr; v.est = est;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [DW-1:0] ed,
                           input logic [1:0] eocc, input logic einr, input logic [CW-1:0] est);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    check({tag, ".out_data"}, 64'(out_data), 64'(ed));
    check({tag, ".occupancy"}, 64'(occupancy), 64'(eocc));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(einr));
    check({tag, ".stall"}, 64'(stall_cycles), 64'(est));
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] d,
                       input logic ordy, input logic clr);
    flush = fl; in_valid = iv; in_data = d; out_ready = ordy; clr_cnt = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [CW-1:0] exp_st;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 41'h0, 1'b0, 1'b0);

    //        fl    iv    data     ordy  clr   ev    exp_data occ    inr   stall
    // Streaming: one entry per cycle, latency 1.
    vecs[0]  = mk(1'b0, 1'b1, 41'h1,   1'b1, 1'b0, 1'b1, 41'h1,   2'd1, 1'b1, 4'd0);
    vecs[1]  = mk(1'b0, 1'b1, 41'h2,   1'b1, 1'b0, 1'b1, 41'h2,   2'd1, 1'b1, 4'd0);
    vecs[2]  = mk(1'b0, 1'b1, 41'h3,   1'b1, 1'b0, 1'b1, 41'h3,   2'd1, 1'b1, 4'd0);
    vecs[3]  = mk(1'b0, 1'b1, 41'h4,   1'b1, 1'b0, 1'b1, 41'h4,   2'd1, 1'b1, 4'd0);
    vecs[4]  = mk(1'b0, 1'b0, 41'h0,   1'b1, 1'b0, 1'b0, NOP,     2'd0, 1'b1, 4'd0);
    // Backpressure: fill to FULL, hold, then drain in order.
    vecs[5]  = mk(1'b0, 1'b1, 41'h0AA, 1'b0, 1'b0, 1'b1, 41'h0AA, 2'd1, 1'b1, 4'd0);
    vecs[6]  = mk(1'b0, 1'b1, 41'h0BB, 1'b0, 1'b0, 1'b1, 41'h0AA, 2'd2, 1'b0, 4'd1);
    vecs[7]  = mk(1'b0, 1'b0, 41'h0,   1'b0, 1'b0, 1'b1, 41'h0AA, 2'd2, 1'b0, 4'd2);
    vecs[8]  = mk(1'b0, 1'b0, 41'h0,   1'b1, 1'b0, 1'b1, 41'h0BB, 2'd1, 1'b1, 4'd2);
    vecs[9]  = mk(1'b0, 1'b0, 41'h0,   1'b1, 1'b0, 1'b0, NOP,     2'd0, 1'b1, 4'd2);
    // Simultaneous push and pop in ONE.
    vecs[10] = mk(1'b0, 1'b1, 41'h111, 1'b0, 1'b0, 1'b1, 41'h111, 2'd1, 1'b1, 4'd2);
    vecs[11] = mk(1'b0, 1'b1, 41'h222, 1'b1, 1'b0, 1'b1, 41'h222, 2'd1, 1'b1, 4'd2);
    // Fill, push attempt while FULL is refused, then flush with a push pending.
    vecs[12] = mk(1'b0, 1'b1, 41'h0AB, 1'b0, 1'b0, 1'b1, 41'h222, 2'd2, 1'b0, 4'd3);
    vecs[13] = mk(1'b0, 1'b1, 41'h0DD, 1'b0, 1'b0, 1'b1, 41'h222, 2'd2, 1'b0, 4'd4);
    vecs[14] = mk(1'b1, 1'b1, 41'h0CC, 1'b0, 1'b0, 1'b0, NOP,     2'd0, 1'b1, 4'd5);
    vecs[15] = mk(1'b0, 1'b0, 41'h0,   1'b1, 1'b0, 1'b0, NOP,     2'd0, 1'b1, 4'd5);
    vecs[16] = mk(1'b0, 1'b0, 41'h0,   1'b1, 1'b1, 1'b0, NOP,     2'd0, 1'b1, 4'd0);

    // Reset state.
    tick();
    tick();
    check_all("reset", 1'b0, NOP, 2'd0, 1'b1, 4'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, vecs[i].clr);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eocc,
                vecs[i].einr, vecs[i].est);
    end

    // Counter saturation: 20 blocked cycles saturate at 15.
    drive(1'b0, 1'b1, 41'h0EE, 1'b0, 1'b0);
    tick();
    check_all("sat_push", 1'b1, 41'h0EE, 2'd1, 1'b1, 4'd0);
    drive(1'b0, 1'b0, 41'h0, 1'b0, 1'b0);
    exp_st = 4'd0;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_st = (exp_st == 4'd15) ? 4'd15 : exp_st + 4'd1;
      check($sformatf("sat_cnt%0d", k), 64'(stall_cycles), 64'(exp_st));
    end
    check("sat_final", 64'(stall_cycles), 64'(4'd15));
    check("sat_data_held", 64'(out_data), 64'(41'h0EE));
    drive(1'b0, 1'b0, 41'h0, 1'b0, 1'b1);
    tick();
    check("clr_cnt", 64'(stall_cycles), 64'(4'd0));
    drive(1'b0, 1'b0, 41'h0, 1'b0, 1'b0);
    tick();
    check("cnt_resume", 64'(stall_cycles), 64'(4'd1));
    drive(1'b0, 1'b0, 41'h0, 1'b1, 1'b0);
    tick();
    check_all("sat_drain", 1'b0, NOP, 2'd0, 1'b1, 4'd1);

    // Async reset mid-cycle while FULL.
    drive(1'b0, 1'b1, 41'h0A1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 41'h0A2, 1'b0, 1'b0);
    tick();
    check_all("pre_rst_full", 1'b1, 41'h0A1, 2'd2, 1'b0, 4'd2);
    drive(1'b0, 1'b0, 41'h0, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check_all("async_rst", 1'b0, NOP, 2'd0, 1'b1, 4'd0);
    tick();
    reset = 1'b1;
    #2;
    drive(1'b0, 1'b1, 41'h055, 1'b0, 1'b0);
    tick();
    check_all("post_rst_push", 1'b1, 41'h055, 2'd1, 1'b1, 4'd0);
    drive(1'b0, 1'b0, 41'h0, 1'b1, 1'b0);
    tick();
    check_all("post_rst_pop", 1'b0, NOP, 2'd0, 1'b1, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
